uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between several byte sources, e.g. the switch/button path and the PS/2 keyboard-to-ASCII path.
- Each source offers one byte at a time over a valid/ready handshake. The block selects a winner, latches the byte and issues a one-cycle start pulse to the UART.
- It then tracks the UART busy flag until the frame completes.
- It replaces ad-hoc "whoever fires first" send logic, so simultaneous requests never collide or get lost.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 8, byte width carried to the UART.
- BUSY_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start before treating the frame as complete.

Ports:
- clk  input  1  system clock (100 MHz).
- rst_n  input  1  reset; synchronous, active-low.
- req_valid  input  NUM_REQ  requester i has a byte to send.
- req_data  input  NUM_REQ*DATA_W  byte of requester i in bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot; byte of requester i is accepted this cycle.
- tx_data  output  DATA_W  byte presented to the UART; stable from tx_start until return to IDLE.
- tx_start  output  1  one-cycle send strobe to the UART.
- tx_busy  input  1  UART transmitter busy.
- grant_id  output  clog2(NUM_REQ)  index of the last accepted requester.
- arb_busy  output  1  high whenever state is not IDLE.
- byte_count  output  16  number of bytes started; wraps 0xFFFF to 0.

Behaviour:
- Reset values (clock edge with rst_n=0): state IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=0, arb_busy=0, byte_count=0, RR pointer=0, timeout counter=0.
- Reset mid-frame aborts the sequence immediately. No further tx_start is issued for the aborted byte; the UART finishes on its own.

State machine:
- IDLE: if any req_valid is high, req_ready[w] is driven combinationally high for the winner w. On that edge:
  - tx_data <= req_data[w]
  - grant_id <= w
  - RR pointer <= (w+1) mod NUM_REQ
  - next state is START.
- START: tx_start=1 for exactly this cycle; byte_count increments; next state WAIT_BUSY; timeout counter cleared.
- WAIT_BUSY:
  - If tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1, go to IDLE (UART missed or absorbed the strobe).
- WAIT_DONE: stay while tx_busy=1; on tx_busy=0 go to IDLE.
- Latency: valid seen in IDLE → tx_start 1 cycle later. Back-to-back minimum spacing between accepts is 3 cycles plus the UART frame time.

Arbitration and handshake rules:
- Round-robin: search starts at the RR pointer and wraps upward; the first asserted req_valid wins.
- With a single active requester, it wins every turn.
- req_ready is 0 in all states except IDLE, so a requester must hold valid and data stable until it sees ready.
- Deasserting valid before ready means no transfer and no side effects.
- tx_busy already high while in IDLE does not block acceptance: WAIT_BUSY exits at once and WAIT_DONE waits for the fall.

Optional Feature:
- Macro: UART_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index wins; the RR pointer is not implemented and grant order ignores history.
- Undefined (default): round-robin as above.

Decomposition:
- Package uart_arb_pkg holds:
  - state encoding (IDLE=0, START=1, WAIT_BUSY=2, WAIT_DONE=3)
  - default BUSY_TIMEOUT constant
  - byte_count width constant (16).
- One natural sub-module, rr_select: combinational round-robin/fixed-priority picker taking NUM_REQ valids and the pointer, returning a one-hot grant and an index.
- The FSM, data latch and counters stay in uart_tx_arbiter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=2'b11 → req_ready=0, tx_start=0, byte_count=0, arb_busy=0.
- Single send: req_valid[0]=1, data 0x41; UART model raises busy 2 cycles after start and holds it 10 cycles → exactly one tx_start, tx_data=0x41, byte_count=1, IDLE after busy falls.
- Contention: both valid continuously, req0=0x11, req1=0x22 → tx order 0x11, 0x22, 0x11, 0x22; grant_id alternates 0,1,0,1.
- Timeout: tx_busy tied 0, req1 sends 0x7F → return to IDLE exactly BUSY_TIMEOUT cycles after entering WAIT_BUSY; next byte accepted.
- Mid-frame reset: assert rst_n=0 during WAIT_DONE → outputs return to reset values next edge and no extra tx_start.
- With UART_ARB_FIXED_PRIO_EN defined: both valid continuously → req0 wins every grant and req1 is starved until req0 drops valid.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared state encoding and constants for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int unsigned BUSY_TIMEOUT_DEF = 16;
    localparam int unsigned BYTE_CNT_W       = 16;

    // Next requester index after idx, wrapping at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational requester picker: searches upward from ptr, wrapping, and
// returns the first asserted valid as a one-hot grant plus its index.
module rr_select #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int unsigned cand;
        cand  = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr) + k) % NUM_REQ;
            if (!any && valid[cand[IDX_W-1:0]]) begin
                any                     = 1'b1;
                grant[cand[IDX_W-1:0]]  = 1'b1;
                idx                     = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources over valid/ready.
// Define UART_ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_start,
    input  logic                        tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        arb_busy,
    output logic [BYTE_CNT_W-1:0]       byte_count
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned TO_W  = $clog2(BUSY_TIMEOUT) + 1;

    arb_state_e              state_q, state_d;
    logic [DATA_W-1:0]       tx_data_q, tx_data_d;
    logic [IDX_W-1:0]        grant_id_q, grant_id_d;
    logic [BYTE_CNT_W-1:0]   byte_count_q, byte_count_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;

    logic [IDX_W-1:0]        rr_ptr;
    logic [NUM_REQ-1:0]      sel_grant;
    logic [IDX_W-1:0]        sel_idx;
    logic                    sel_any;
    logic                    accept;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (sel_grant),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    assign accept = rst_n && (state_q == ST_IDLE) && sel_any;

`ifdef UART_ARB_FIXED_PRIO_EN
    // A search that always starts at zero is plain lowest-index priority.
    assign rr_ptr = '0;
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    assign rr_ptr = rr_ptr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = IDX_W'(wrap_inc(32'(sel_idx), NUM_REQ));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        grant_id_d   = grant_id_q;
        byte_count_d = byte_count_q;
        to_cnt_d     = to_cnt_q;
        req_ready    = '0;
        tx_start     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_ready  = sel_grant;
                    tx_data_d  = req_data[sel_idx*DATA_W +: DATA_W];
                    grant_id_d = sel_idx;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                tx_start     = 1'b1;
                byte_count_d = byte_count_q + BYTE_CNT_W'(1);
                to_cnt_d     = '0;
                state_d      = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // Give up after BUSY_TIMEOUT cycles if the UART never reports busy.
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tx_data_q    <= '0;
            grant_id_q   <= '0;
            byte_count_q <= '0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            grant_id_q   <= grant_id_d;
            byte_count_q <= byte_count_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign grant_id   = grant_id_q;
    assign byte_count = byte_count_q;
    assign arb_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a transaction-level model of
// arbitration order, frame timing (busy/timeout) and byte counting.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ      = 2;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned BUSY_TIMEOUT = 16;
    localparam int          INF          = 32'h3fff_ffff;

    localparam int M_HOLD    = 0;
    localparam int M_RAND    = 1;
    localparam int M_CONT    = 2;
    localparam int M_REFILL1 = 3;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_busy;
    logic [0:0]                grant_id;
    logic                      arb_busy;
    logic [15:0]               byte_count;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_W       (DATA_W),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .arb_busy   (arb_busy),
        .byte_count (byte_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Model state
    int         cyc;
    int         idle_at;
    int         start_at;
    int         m_ptr;
    int         m_cnt;
    int         m_gid;
    logic [7:0] m_byte;
    int         busy_lo[$];
    int         busy_hi[$];

    // Requester and UART stimulus state
    logic [NUM_REQ-1:0] hold;
    logic [7:0]         hold_data [NUM_REQ];
    logic [NUM_REQ-1:0] seen_ready;
    int                 mode;
    int                 bpol;
    logic               force_rst;
    logic               rst_pending;
    int                 rst_hits;
    logic [7:0]         tx_log[$];
    int                 gid_log[$];
    int                 cur_len;
    int                 last_len;

    function automatic logic busy_at(input int t);
        foreach (busy_lo[k]) begin
            if (t >= busy_lo[k] && t < busy_hi[k]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // After a start at cycle s: wait up to BUSY_TIMEOUT cycles for busy,
    // then for busy to drop; the arbiter is idle the cycle after.
    function automatic int idle_after(input int s);
        int t;
        t = s + 1;
        while (t <= s + int'(BUSY_TIMEOUT) && !busy_at(t)) t++;
        if (t > s + int'(BUSY_TIMEOUT)) return s + int'(BUSY_TIMEOUT) + 1;
        while (busy_at(t)) t++;
        return t + 1;
    endfunction

    function automatic logic [NUM_REQ-1:0] pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            int i;
            i = (p + k) % int'(NUM_REQ);
            if (v[i]) return NUM_REQ'(1) << i;
        end
        return '0;
    endfunction

    task automatic model_reset();
        idle_at  = 0;
        start_at = -1;
        m_ptr    = 0;
        m_cnt    = 0;
        m_gid    = 0;
        m_byte   = 8'h00;
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] exp_ready;
        logic               in_idle;
        int                 d;
        int                 len;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (seen_ready[i]) hold[i] = 1'b0;
            case (mode)
                M_RAND: begin
                    if (!hold[i]) begin
                        if ($urandom_range(2) == 0) begin
                            hold[i]      = 1'b1;
                            hold_data[i] = 8'($urandom);
                        end
                    end else if ($urandom_range(15) == 0) begin
                        hold[i] = 1'b0;
                    end
                end
                M_CONT: begin
                    hold[i]      = 1'b1;
                    hold_data[i] = (i == 0) ? 8'h11 : 8'h22;
                end
                M_REFILL1: begin
                    if (i == 1 && !hold[i]) begin
                        hold[i]      = 1'b1;
                        hold_data[i] = 8'($urandom);
                    end
                end
                default: ;
            endcase
        end
        req_valid = hold;
        for (int i = 0; i < int'(NUM_REQ); i++) req_data[i*DATA_W +: DATA_W] = hold_data[i];
        tx_busy = busy_at(cyc);
        rst_n   = 1'b1;
        if (force_rst) rst_n = 1'b0;
        // Arbiter is in WAIT_DONE this cycle: busy was seen last cycle after START.
        if (rst_pending && cyc < idle_at && cyc - 1 > start_at && start_at >= 0
            && busy_at(cyc - 1) && busy_at(cyc)) begin
            rst_n       = 1'b0;
            rst_pending = 1'b0;
            rst_hits++;
        end
        #1;
        in_idle   = (cyc >= idle_at);
        exp_ready = (rst_n && in_idle) ? pick(hold, m_ptr) : '0;
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("tx_start", 32'(tx_start), 32'(cyc == start_at));
        check_eq("arb_busy", 32'(arb_busy), 32'(!in_idle));
        check_eq("byte_count", 32'(byte_count), 32'(m_cnt));
        check_eq("grant_id", 32'(grant_id), 32'(m_gid));
        if (!in_idle) check_eq("tx_data", 32'(tx_data), 32'(m_byte));

        if (arb_busy === 1'b1) begin
            cur_len++;
        end else if (cur_len > 0) begin
            last_len = cur_len;
            cur_len  = 0;
        end

        if (cyc == start_at) begin
            tx_log.push_back(tx_data);
            gid_log.push_back(int'(grant_id));
            m_cnt = (m_cnt + 1) & 16'hFFFF;
            d   = INF;
            len = 0;
            case (bpol)
                0: begin d = int'($urandom_range(4, 1));  len = int'($urandom_range(12, 1)); end
                2: begin d = int'($urandom_range(24, 1)); len = int'($urandom_range(8, 1));  end
                3: begin d = 2; len = 10; end
                default: ;
            endcase
            if (d != INF) begin
                busy_lo.push_back(cyc + d);
                busy_hi.push_back(cyc + d + len);
            end
            idle_at = idle_after(cyc);
        end

        seen_ready = rst_n ? req_ready : '0;
        if (!rst_n) begin
            model_reset();
        end else if (exp_ready != '0) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (exp_ready[i]) begin
                    m_gid  = i;
                    m_byte = hold_data[i];
`ifdef UART_ARB_FIXED_PRIO_EN
                    m_ptr  = 0;
`else
                    m_ptr  = (i + 1) % int'(NUM_REQ);
`endif
                end
            end
            start_at = cyc + 1;
            idle_at  = INF;
        end
    endtask

    task automatic drain();
        mode = M_HOLD;
        hold = '0;
        for (int k = 0; k < 400; k++) begin
            step();
            if (cyc >= idle_at) break;
        end
    endtask

    initial begin
        cyc         = 0;
        hold        = '0;
        seen_ready  = '0;
        mode        = M_HOLD;
        bpol        = 0;
        force_rst   = 1'b0;
        rst_pending = 1'b0;
        rst_hits    = 0;
        cur_len     = 0;
        last_len    = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) hold_data[i] = 8'h00;

        // Reset held with both requesters asking
        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = {8'h22, 8'h11};
        tx_busy   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_tx_start", 32'(tx_start), 32'd0);
        check_eq("rst_byte_count", 32'(byte_count), 32'd0);
        check_eq("rst_arb_busy", 32'(arb_busy), 32'd0);
        check_eq("rst_grant_id", 32'(grant_id), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        model_reset();

        // Single send of 0x41, busy 2 cycles after start for 10 cycles
        bpol         = 3;
        hold[0]      = 1'b1;
        hold_data[0] = 8'h41;
        repeat (30) step();
        check_eq("single_starts", 32'(tx_log.size()), 32'd1);
        if (tx_log.size() > 0) check_eq("single_data", 32'(tx_log[0]), 32'h41);
        check_eq("single_count", 32'(byte_count), 32'd1);
        check_eq("single_idle", 32'(arb_busy), 32'd0);

        // Contention from a fresh pointer
        drain();
        force_rst = 1'b1;
        step();
        force_rst = 1'b0;
        tx_log.delete();
        gid_log.delete();
        bpol = 0;
        mode = M_CONT;
        for (int k = 0; k < 400 && tx_log.size() < 4; k++) step();
        check_eq("cont_starts", 32'(tx_log.size() >= 4), 32'd1);
        if (tx_log.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
                check_eq("cont_order", 32'(tx_log[k]), 32'h11);
                check_eq("cont_gid", 32'(gid_log[k]), 32'd0);
`else
                check_eq("cont_order", 32'(tx_log[k]), (k % 2 == 0) ? 32'h11 : 32'h22);
                check_eq("cont_gid", 32'(gid_log[k]), 32'(k % 2));
`endif
            end
        end

        // Timeout: busy never rises, req1 keeps offering bytes
        drain();
        tx_log.delete();
        cur_len      = 0;
        last_len     = 0;
        bpol         = 1;
        mode         = M_REFILL1;
        hold[1]      = 1'b1;
        hold_data[1] = 8'h7F;
        for (int k = 0; k < 60 && last_len == 0; k++) step();
        if (tx_log.size() > 0) check_eq("tmo_data", 32'(tx_log[0]), 32'h7F);
        check_eq("tmo_frame_len", 32'(last_len), 32'(BUSY_TIMEOUT + 1));
        repeat (30) step();
        check_eq("tmo_next_accept", 32'(tx_log.size() >= 2), 32'd1);

        // Randomized traffic including UART pulses that outlive the timeout
        drain();
        bpol = 2;
        mode = M_RAND;
        repeat (2500) step();

        // Resets landing in WAIT_DONE
        bpol = 0;
        for (int r = 0; r < 3; r++) begin
            rst_pending = 1'b1;
            for (int k = 0; k < 300 && rst_pending; k++) step();
            repeat (20) step();
        end
        check_eq("midreset_hits", 32'(rst_hits), 32'd3);

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
